// File: rtl/raifes_gpio_in_cond_if.sv
// Control/status bundle between the GPIO slave side and the input conditioner.
// The master drives the debounce limit, edge enables and pending clears;
// the conditioner (slave) returns the clean level, edge pulses and pending flags.
interface raifes_gpio_in_cond_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
);
  logic [CNT_WIDTH-1:0] db_limit;
  logic [WIDTH-1:0]     rise_en;
  logic [WIDTH-1:0]     fall_en;
  logic [WIDTH-1:0]     irq_clr;
  logic [WIDTH-1:0]     gpio_i;
  logic [WIDTH-1:0]     rise_p;
  logic [WIDTH-1:0]     fall_p;
  logic [WIDTH-1:0]     irq_pend;
  logic                 irq;

  modport master (
    output db_limit, rise_en, fall_en, irq_clr,
    input  gpio_i, rise_p, fall_p, irq_pend, irq
  );

  modport slave (
    input  db_limit, rise_en, fall_en, irq_clr,
    output gpio_i, rise_p, fall_p, irq_pend, irq
  );
endinterface

// File: rtl/raifes_gpio_in_cond.sv
// GPIO input conditioner: per-bit synchroniser, programmable debounce,
// registered edge pulses and sticky write-1-to-clear interrupt-pending flags.
// Every bit runs completely independently of the others.
module raifes_gpio_in_cond #(
  parameter int WIDTH       = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     pad_i,
  raifes_gpio_in_cond_if.slave bus
);

  localparam int                   LAST    = SYNC_STAGES - 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH:0]   LIM_ONE = {{CNT_WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]     s;
  logic [CNT_WIDTH-1:0] cnt_q  [WIDTH];
  logic [CNT_WIDTH:0]   limit_eff;
  logic [WIDTH-1:0]     accept;
  logic [WIDTH-1:0]     lvl_q;
  logic [WIDTH-1:0]     rise_q;
  logic [WIDTH-1:0]     fall_q;
  logic [WIDTH-1:0]     pend_q;

  // Synchroniser chain bringing the asynchronous pad levels into clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= pad_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[LAST];

  // A limit of zero is treated as one; one extra bit keeps cnt+1 from wrapping.
  assign limit_eff = (bus.db_limit == '0) ? LIM_ONE : {1'b0, bus.db_limit};

  // Accept a new level once this mismatch cycle completes a long enough run.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (s[i] != lvl_q[i]) && (({1'b0, cnt_q[i]} + LIM_ONE) >= limit_eff);
    end
  end

  // Mismatch run counters: cleared on agreement or acceptance, else advanced.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((s[i] == lvl_q[i]) || accept[i]) cnt_q[i] <= '0;
        else                                  cnt_q[i] <= cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Clean level, edge pulses and sticky pending flags; a set beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      pend_q <= '0;
    end else begin
      lvl_q  <= lvl_q ^ accept;
      rise_q <= accept & s;
      fall_q <= accept & ~s;
      pend_q <= (pend_q & ~bus.irq_clr)
              | (accept & s & bus.rise_en)
              | (accept & ~s & bus.fall_en);
    end
  end

  assign bus.gpio_i   = lvl_q;
  assign bus.rise_p   = rise_q;
  assign bus.fall_p   = fall_q;
  assign bus.irq_pend = pend_q;
  assign bus.irq      = |pend_q;

endmodule

// File: tb/tb_raifes_gpio_in_cond.sv
// Self-checking bench for raifes_gpio_in_cond: a run-length behavioural model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_raifes_gpio_in_cond;

  localparam int WIDTH = 8;
  localparam int CNTW  = 16;
  localparam int SYNC  = 2;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] pad;

  int errors = 0;
  int checks = 0;

  raifes_gpio_in_cond_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNTW)) bus ();

  raifes_gpio_in_cond #(
    .WIDTH(WIDTH), .CNT_WIDTH(CNTW), .SYNC_STAGES(SYNC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pad_i (pad),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pad history delayed by the synchroniser depth, and per
  // bit the length of the current run of cycles disagreeing with the clean level.
  logic [WIDTH-1:0] hist [SYNC];
  logic [WIDTH-1:0] m_lvl, m_rise, m_fall, m_pend;
  int               run [WIDTH];

  always @(posedge clk or posedge reset) begin
    logic [WIDTH-1:0] seen;
    logic [WIDTH-1:0] acc;
    int               lim;
    if (reset) begin
      for (int k = 0; k < SYNC; k++) hist[k] = '0;
      for (int b = 0; b < WIDTH; b++) run[b] = 0;
      m_lvl = '0; m_rise = '0; m_fall = '0; m_pend = '0;
    end else begin
      seen = hist[SYNC-1];
      lim  = (bus.db_limit == 0) ? 1 : int'(bus.db_limit);
      acc  = '0;
      for (int b = 0; b < WIDTH; b++) begin
        if (seen[b] != m_lvl[b]) begin
          run[b] = run[b] + 1;
          if (run[b] >= lim) begin
            acc[b] = 1'b1;
            run[b] = 0;
          end
        end else begin
          run[b] = 0;
        end
      end
      m_rise = acc & seen;
      m_fall = acc & ~seen;
      m_pend = (m_pend & ~bus.irq_clr) | (m_rise & bus.rise_en) | (m_fall & bus.fall_en);
      m_lvl  = m_lvl ^ acc;
      for (int k = SYNC - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = pad;
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    check("model gpio_i",   {8'h00, bus.gpio_i},   {8'h00, m_lvl});
    check("model rise_p",   {8'h00, bus.rise_p},   {8'h00, m_rise});
    check("model fall_p",   {8'h00, bus.fall_p},   {8'h00, m_fall});
    check("model irq_pend", {8'h00, bus.irq_pend}, {8'h00, m_pend});
    check("model irq",      {15'h0, bus.irq},      {15'h0, |m_pend});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int n_rise;
  int n_fall;

  task automatic count_edges(input int n, input int idx);
    for (int c = 0; c < n; c++) begin
      tick(1);
      if (bus.rise_p[idx]) n_rise++;
      if (bus.fall_p[idx]) n_fall++;
    end
  endtask

  task automatic applyStimulus();
    logic [7:0] vec  [10] = '{8'hFF, 8'hF0, 8'hA5, 8'h5A, 8'h5B, 8'h00, 8'h3C, 8'hC3, 8'hC3, 8'h00};
    int         hold [10] = '{3, 1, 4, 2, 1, 3, 2, 1, 5, 6};

    reset = 1'b1; pad = '0;
    bus.db_limit = 16'd4; bus.rise_en = 8'hFF; bus.fall_en = 8'h00; bus.irq_clr = 8'h00;
    tick(3);
    check("reset gpio_i", {8'h00, bus.gpio_i}, 16'h0000);
    check("reset irq", {15'h0, bus.irq}, 16'h0000);
    reset = 1'b0;
    tick(3);

    // Bit 0 step with limit 4 lands on the 6th edge.
    pad = 8'h01;
    tick(5);
    check("step edge5 gpio_i", {8'h00, bus.gpio_i}, 16'h0000);
    tick(1);
    check("step edge6 gpio_i", {8'h00, bus.gpio_i}, 16'h0001);
    check("step rise_p", {8'h00, bus.rise_p}, 16'h0001);
    check("step irq_pend", {8'h00, bus.irq_pend}, 16'h0001);
    check("step irq", {15'h0, bus.irq}, 16'h0001);
    tick(1);
    check("step rise_p gone", {8'h00, bus.rise_p}, 16'h0000);

    // Bit 3 glitch of 3 cycles rejected, then a 4-cycle pulse accepted.
    pad = 8'h09; tick(3); pad = 8'h01; tick(12);
    check("glitch gpio_i", {8'h00, bus.gpio_i}, 16'h0001);
    check("glitch irq_pend", {8'h00, bus.irq_pend}, 16'h0001);
    n_rise = 0; n_fall = 0;
    pad = 8'h09; tick(4); pad = 8'h01;
    count_edges(20, 3);
    check("pulse4 rises", 16'(n_rise), 16'd1);
    check("pulse4 falls", 16'(n_fall), 16'd1);
    check("pulse4 irq_pend", {8'h00, bus.irq_pend}, 16'h0009);
    bus.irq_clr = 8'hFF; tick(1); bus.irq_clr = 8'h00;
    check("clear all irq_pend", {8'h00, bus.irq_pend}, 16'h0000);

    // Bit 7 with only the falling edge enabled.
    bus.rise_en = 8'h00; bus.fall_en = 8'h80;
    n_rise = 0; n_fall = 0;
    pad = 8'h81; count_edges(10, 7);
    check("b7 high irq_pend", {8'h00, bus.irq_pend}, 16'h0000);
    check("b7 high gpio_i", {8'h00, bus.gpio_i}, 16'h0081);
    pad = 8'h01; count_edges(10, 7);
    count_edges(10, 7);
    check("b7 rises", 16'(n_rise), 16'd1);
    check("b7 falls", 16'(n_fall), 16'd1);
    check("b7 irq_pend", {8'h00, bus.irq_pend}, 16'h0080);
    bus.irq_clr = 8'hFF; tick(1); bus.irq_clr = 8'h00;

    // Bit 2: set beats a simultaneous clear, next clear drops it.
    bus.rise_en = 8'h04; bus.fall_en = 8'h04;
    pad = 8'h05; tick(8);
    check("b2 rise irq_pend", {8'h00, bus.irq_pend}, 16'h0004);
    pad = 8'h01; tick(5);
    bus.irq_clr = 8'h04; tick(1);
    check("b2 fall_p", {8'h00, bus.fall_p}, 16'h0004);
    check("b2 set wins", {8'h00, bus.irq_pend}, 16'h0004);
    tick(1);
    check("b2 cleared", {8'h00, bus.irq_pend}, 16'h0000);
    check("b2 irq low", {15'h0, bus.irq}, 16'h0000);
    bus.irq_clr = 8'h00;

    // Bit 5 high through reset with limit 0: visible on the 3rd edge.
    pad = 8'h20; reset = 1'b1;
    bus.db_limit = 16'd0; bus.rise_en = 8'h00; bus.fall_en = 8'h00;
    tick(2);
    reset = 1'b0;
    tick(2);
    check("b5 edge2 gpio_i", {8'h00, bus.gpio_i}, 16'h0000);
    tick(1);
    check("b5 edge3 gpio_i", {8'h00, bus.gpio_i}, 16'h0020);
    check("b5 rise_p", {8'h00, bus.rise_p}, 16'h0020);

    // Asynchronous reset in the middle of a long debounce.
    bus.db_limit = 16'd100; bus.rise_en = 8'hFF;
    pad = 8'h21; tick(20);
    check("pre-reset gpio_i", {8'h00, bus.gpio_i}, 16'h0020);
    #1 reset = 1'b1;
    #1;
    check("async reset gpio_i", {8'h00, bus.gpio_i}, 16'h0000);
    check("async reset rise_p", {8'h00, bus.rise_p}, 16'h0000);
    check("async reset irq_pend", {8'h00, bus.irq_pend}, 16'h0000);
    pad = 8'h00; bus.rise_en = 8'h00;
    tick(2);
    reset = 1'b0;
    tick(2);

    // Limit lowered from 50 to 5 while bit 1 has counted 20 mismatches.
    bus.db_limit = 16'd50;
    pad = 8'h02; tick(22);
    check("b1 cnt20 gpio_i", {8'h00, bus.gpio_i}, 16'h0000);
    bus.db_limit = 16'd5; tick(1);
    check("b1 lowered gpio_i", {8'h00, bus.gpio_i}, 16'h0002);
    check("b1 lowered rise_p", {8'h00, bus.rise_p}, 16'h0002);

    // Multi-bit burst with a short limit, checked by the model only.
    bus.db_limit = 16'd2; bus.rise_en = 8'hF0; bus.fall_en = 8'h0F;
    for (int i = 0; i < 10; i++) begin
      pad = vec[i];
      if (i == 6) bus.irq_clr = 8'h30;
      if (i == 8) bus.irq_clr = 8'h00;
      tick(hold[i]);
    end
    pad = 8'h00; tick(10);
  endtask

  initial begin
    applyStimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
